zxunouart_phy: RTL and testbench
================================

# zxunouart_phy

Serial line side of the ZX-Uno UART register pair (UARTDATA 0xC6 / UARTSTAT 0xC7). Accepts byte strobes from the register block, buffers them in a TX FIFO and serializes them as 8N1 on `txd`. Deserializes `rxd` into one-cycle byte strobes for the register block's RX FIFO. Drives `rts_n` from that FIFO's almost-full flag. Sits between the register block and the board UART pins (ESP8266 / RS-232 header).

## Interface
Parameters:
- `CLK_DIV`, default 243: `clk_bus` cycles per bit (28 MHz / 115200); minimum 4.
- `TX_FIFO_AW`, default 4: TX FIFO address width; depth is 2^TX_FIFO_AW.

Ports:
- `clk_bus`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_tx_data`  in  8  byte to send; valid while `uart_tx_req` is high.
- `uart_tx_req`  in  1  one-cycle write strobe.
- `uart_rx_data`  out  8  last received byte; held until the next byte.
- `uart_rx_req`  out  1  one-cycle strobe for a good byte.
- `uart_rx_fifo_full`  in  1  downstream RX FIFO almost full.
- `txd`  out  1  serial out, idle high.
- `rxd`  in  1  serial in, asynchronous.
- `rts_n`  out  1  low means the host may send.
- `cts_n`  in  1  low means the peer accepts data; see Configuration.
- `tx_busy`  out  1  FIFO not empty or a frame is in flight.
- `tx_overflow`  out  1  sticky; set when a byte is dropped; cleared only by `reset`.
- `rx_frame_err`  out  1  one-cycle pulse on a bad stop bit.

## Operation
- Frame format: 8N1, LSB first. Start bit 0, eight data bits, one stop bit 1.
- **TX path**
  - `uart_tx_req` writes `uart_tx_data` into the FIFO in the same cycle.
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and `tx_overflow` is set.
  - If the FIFO is full and a pop happens in the same cycle, the write is accepted.
- **TX FSM:** TX_IDLE → TX_START → TX_DATA (bits 0..7) → TX_STOP → TX_IDLE.
  - In TX_IDLE with the FIFO non-empty (and CTS permitting), pop the FIFO and latch the byte into the shift register.
  - Each state holds `txd` for exactly CLK_DIV cycles.
  - After TX_STOP, a non-empty FIFO starts the next frame with no idle gap.
- **RX path**
  - `rxd` passes through a 2-FF synchronizer.
  - RX_IDLE: a sync'd falling edge moves to RX_START.
  - RX_START: at CLK_DIV/2 (integer division), re-sample. High means glitch, return to RX_IDLE. Low means go to RX_DATA.
  - RX_DATA: sample every CLK_DIV cycles, 8 samples shifted in LSB first.
  - RX_STOP: sample once more after CLK_DIV.
    - High: load `uart_rx_data` and pulse `uart_rx_req` once, then RX_IDLE.
    - Low: pulse `rx_frame_err`, no `uart_rx_req`, move to RX_WAIT.
  - RX_WAIT: stay until the sync'd line is high, then RX_IDLE.
- RX has no drop logic. Flow control relies on `rts_n`: the downstream FIFO asserts almost-full with 13 slots spare.
- `rts_n` is `uart_rx_fifo_full` registered once.
- Reset values: `txd`=1, `rts_n`=1, `uart_rx_data`=0x00, `uart_rx_req`=0, `tx_busy`=0, `tx_overflow`=0, `rx_frame_err`=0. Both FSMs idle and the TX FIFO empty.
- Reset asserted mid-frame aborts immediately: `txd` goes high asynchronously and the partial RX byte is discarded.

## Timing
- TX latency, measured from the `uart_tx_req` cycle (cycle 0) into an empty FIFO with the line clear:
  - cycle 1: pop.
  - cycle 2: `txd` falls.
- One frame lasts 10·CLK_DIV cycles. Back-to-back frames are exactly 10·CLK_DIV cycles apart.
- RX latency: `uart_rx_req` pulses 2 (sync) + CLK_DIV/2 + 9·CLK_DIV cycles after the `rxd` falling edge, within ±1 cycle.
- Bit counters are $clog2(CLK_DIV) bits wide and reload to CLK_DIV−1 on each bit boundary.
- `rts_n` lags `uart_rx_fifo_full` by 1 cycle.

## Configuration
- `UART_CTS_EN` defined:
  - TX_IDLE starts a frame only while the synchronized `cts_n` is 0. `cts_n` uses its own 2-FF synchronizer.
  - A frame already started always completes.
- `UART_CTS_EN` undefined:
  - `cts_n` is ignored and no synchronizer is built.
  - Frames start whenever the FIFO is non-empty.

## Structure
- Package `uart_phy_pkg`:
  - `tx_state_t` (TX_IDLE, TX_START, TX_DATA, TX_STOP).
  - `rx_state_t` (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT).
  - Localparams for the frame bit count (8) and stop bits (1).
- Sub-module: the codebase's existing `fifo` (ADDR_WIDTH=TX_FIFO_AW, DATA_WIDTH=8) for TX buffering. TX and RX FSMs stay inline.

## Test plan
- All tests use CLK_DIV=8.
- TX single byte: `uart_tx_req` with 0xA5.
  - `txd` falls at cycle 2.
  - Bit pattern 0,1,0,1,0,0,1,0,1,1, each bit held for 8 cycles.
  - `tx_busy` drops after the stop bit.
- TX burst and overflow with TX_FIFO_AW=2: write 6 bytes 0x01..0x06 on consecutive cycles.
  - 0x01..0x05 are sent back-to-back (0x01 is popped before 0x05 arrives).
  - 0x06 is dropped and `tx_overflow` latches 1.
- RX good frame: drive 0x3C at 8 cycles per bit.
  - Exactly one `uart_rx_req` pulse with `uart_rx_data`=0x3C.
  - `rx_frame_err`=0.
- RX framing and glitch:
  - Stop bit driven low: `rx_frame_err` pulses, no `uart_rx_req`, and the next valid 0x55 is received only after the line returns high.
  - A 2-cycle low glitch: no activity on either output.
- Flow control with `UART_CTS_EN`:
  - With `cts_n`=1, a queued 0x10 is not sent.
  - Lowering `cts_n` makes `txd` fall within 4 cycles.
  - `uart_rx_fifo_full` 0→1 gives `rts_n`=1 one cycle later.
- Reset mid-frame: assert `reset` during TX bit 4.
  - `txd`=1 at once and the FIFO is emptied.
  - After release, a new byte 0x81 transmits correctly.

Source files
------------

// File: rtl/uart_phy_pkg.sv
// Shared types and frame constants for the ZX-Uno UART serial PHY.
package uart_phy_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned STOP_BITS  = 1;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with first-word fall-through read data and async active-high reset.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module fifo #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [ADDR_WIDTH:0] PtrOne = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic                  push, pop;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                       (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign pop       = rd_en_i && !empty_o;
    assign push      = wr_en_i && (!full_o || pop);
    assign rd_data_o = mem_q[rptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wptr_d = push ? wptr_q + PtrOne : wptr_q;
        rptr_d = pop  ? rptr_q + PtrOne : rptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/zxunouart_phy.sv
// 8N1 serial PHY for the ZX-Uno UART: TX FIFO + serializer, RX deserializer, RTS from RX FIFO.
// Define UART_CTS_EN to gate new TX frames on a synchronized cts_n.
module zxunouart_phy
    import uart_phy_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 243,
    parameter int unsigned TX_FIFO_AW = 4
) (
    input  logic       clk_bus,
    input  logic       reset,
    input  logic [7:0] uart_tx_data,
    input  logic       uart_tx_req,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_req,
    input  logic       uart_rx_fifo_full,
    output logic       txd,
    input  logic       rxd,
    output logic       rts_n,
    input  logic       cts_n,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       rx_frame_err
);

    localparam int unsigned   CW         = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CntOne     = CW'(1);
    localparam logic [CW-1:0] BitReload  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HalfReload = CW'(CLK_DIV / 2 - 1);
    localparam logic [2:0]    LastBit    = 3'(FRAME_BITS - 1);

    logic [7:0] fifo_rd_data;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic       cts_ok;

    fifo #(
        .ADDR_WIDTH(TX_FIFO_AW),
        .DATA_WIDTH(8)
    ) u_tx_fifo (
        .clk_i    (clk_bus),
        .rst_i    (reset),
        .wr_en_i  (uart_tx_req),
        .wr_data_i(uart_tx_data),
        .rd_en_i  (fifo_pop),
        .rd_data_o(fifo_rd_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

`ifdef UART_CTS_EN
    logic cts_meta_q, cts_sync_q;

    always_ff @(posedge clk_bus or posedge reset) begin
        if (reset) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign cts_ok = ~cts_sync_q;
`else
    logic unused_cts;
    assign unused_cts = cts_n;
    assign cts_ok     = 1'b1;
`endif

    // ---------------- TX ----------------
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_ovf_q, tx_ovf_d;

    always_ff @(posedge clk_bus or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_ovf_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - CntOne;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_ovf_d   = tx_ovf_q | (uart_tx_req & fifo_full & ~fifo_pop);
        unique case (tx_state_q)
            TX_IDLE: begin
                txd_d    = 1'b1;
                tx_cnt_d = tx_cnt_q;
                if (fifo_pop) begin
                    tx_state_d = TX_START;
                    tx_shift_d = fifo_rd_data;
                    tx_cnt_d   = BitReload;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BitReload;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BitReload;
                    if (tx_bit_q == LastBit) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    // Queued data restarts immediately so frames stay back-to-back.
                    if (fifo_pop) begin
                        tx_state_d = TX_START;
                        tx_shift_d = fifo_rd_data;
                        tx_cnt_d   = BitReload;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = !fifo_empty && cts_ok &&
                   ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_cnt_q == '0));
        tx_busy     = !fifo_empty || (tx_state_q != TX_IDLE);
        txd         = txd_q;
        tx_overflow = tx_ovf_q;
    end

    // ---------------- RX ----------------
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_req_q, rx_req_d;
    logic          rx_err_q, rx_err_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          rts_q;

    always_ff @(posedge clk_bus or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rts_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rts_q     <= uart_rx_fifo_full;
        end
    end

    always_ff @(posedge clk_bus or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_req_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_req_q   <= rx_req_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - CntOne;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_req_d   = 1'b0;
        rx_err_d   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = rx_cnt_q;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HalfReload;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = BitReload;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BitReload;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == LastBit) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_req_d   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                rx_cnt_d = rx_cnt_q;
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        uart_rx_data = rx_data_q;
        uart_rx_req  = rx_req_q;
        rx_frame_err = rx_err_q;
        rts_n        = rts_q;
    end

endmodule

// File: tb/tb_zxunouart_phy.sv
// Directed, table-driven bench for zxunouart_phy at CLK_DIV=8, TX_FIFO_AW=2.
// The CTS section is compiled only when UART_CTS_EN is defined.
module tb_zxunouart_phy;

    localparam int unsigned DIV = 8;

    logic       clk_bus = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] uart_tx_data = 8'h00;
    logic       uart_tx_req  = 1'b0;
    logic [7:0] uart_rx_data;
    logic       uart_rx_req;
    logic       uart_rx_fifo_full = 1'b0;
    logic       txd;
    logic       rxd   = 1'b1;
    logic       rts_n;
    logic       cts_n = 1'b0;
    logic       tx_busy;
    logic       tx_overflow;
    logic       rx_frame_err;

    int checks = 0;
    int errors = 0;
    int rx_req_cnt = 0;
    int rx_err_cnt = 0;

    zxunouart_phy #(
        .CLK_DIV   (DIV),
        .TX_FIFO_AW(2)
    ) dut (
        .clk_bus          (clk_bus),
        .reset            (reset),
        .uart_tx_data     (uart_tx_data),
        .uart_tx_req      (uart_tx_req),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_req      (uart_rx_req),
        .uart_rx_fifo_full(uart_rx_fifo_full),
        .txd              (txd),
        .rxd              (rxd),
        .rts_n            (rts_n),
        .cts_n            (cts_n),
        .tx_busy          (tx_busy),
        .tx_overflow      (tx_overflow),
        .rx_frame_err     (rx_frame_err)
    );

    always #5 clk_bus = ~clk_bus;

    always @(negedge clk_bus) begin
        if (!reset) begin
            if (uart_rx_req)  rx_req_cnt = rx_req_cnt + 1;
            if (rx_frame_err) rx_err_cnt = rx_err_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit 0 = start bit, bit 9 = stop bit
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_req;
        int         exp_err;
        logic [7:0] exp_data;
    } rx_vec_t;

    tx_vec_t tx_tab[3];
    rx_vec_t rx_tab[4];

    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Checks txd against frame for every cycle from bit-cycle index first to 79.
    task automatic tx_check(input string name, input logic [9:0] frame, input int first);
        logic bad = 1'b0;
        for (int i = first; i < 10 * DIV; i++) begin
            if (txd !== frame[i / DIV]) bad = 1'b1;
            if ((i % DIV) == DIV - 1) begin
                check($sformatf("%s bit%0d", name, i / DIV), {31'd0, bad}, 32'd0);
                bad = 1'b0;
            end
            tick();
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        uart_tx_data = d;
        uart_tx_req  = 1'b1;
        tick();
        uart_tx_req  = 1'b0;
    endtask

    task automatic rx_drive(input logic [7:0] d, input logic stop, input int tail_low);
        rxd = 1'b0;
        repeat (DIV) tick();
        for (int b = 0; b < 8; b++) begin
            rxd = d[b];
            repeat (DIV) tick();
        end
        rxd = stop;
        repeat (DIV) tick();
        if (tail_low > 0) begin
            rxd = 1'b0;
            repeat (tail_low) tick();
        end
        rxd = 1'b1;
    endtask

    task automatic idle_check(input string name, input int n);
        logic bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
            tick();
        end
        check(name, {31'd0, bad}, 32'd0);
    endtask

    initial begin
        int base_req;
        int base_err;
        int n;

        tx_tab[0] = '{data: 8'hA5, frame: 10'h34A};
        tx_tab[1] = '{data: 8'h00, frame: 10'h200};
        tx_tab[2] = '{data: 8'hFF, frame: 10'h3FE};

        rx_tab[0] = '{data: 8'h3C, stop: 1'b1, exp_req: 1, exp_err: 0, exp_data: 8'h3C};
        rx_tab[1] = '{data: 8'h81, stop: 1'b1, exp_req: 1, exp_err: 0, exp_data: 8'h81};
        rx_tab[2] = '{data: 8'h00, stop: 1'b0, exp_req: 0, exp_err: 1, exp_data: 8'h81};
        rx_tab[3] = '{data: 8'hFF, stop: 1'b1, exp_req: 1, exp_err: 0, exp_data: 8'hFF};

        // Reset values
        repeat (3) tick();
        check("reset txd", {31'd0, txd}, 32'd1);
        check("reset rts_n", {31'd0, rts_n}, 32'd1);
        check("reset rx_data", {24'd0, uart_rx_data}, 32'h00);
        check("reset rx_req", {31'd0, uart_rx_req}, 32'd0);
        check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
        check("reset tx_overflow", {31'd0, tx_overflow}, 32'd0);
        check("reset rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        // TX single frames from table
        foreach (tx_tab[k]) begin
            tx_write(tx_tab[k].data);
            check($sformatf("tx%0d txd high cycle1", k), {31'd0, txd}, 32'd1);
            check($sformatf("tx%0d busy cycle1", k), {31'd0, tx_busy}, 32'd1);
            tick();
            tx_check($sformatf("tx%0d", k), tx_tab[k].frame, 0);
            check($sformatf("tx%0d busy after stop", k), {31'd0, tx_busy}, 32'd0);
            check($sformatf("tx%0d overflow", k), {31'd0, tx_overflow}, 32'd0);
            repeat (3) tick();
        end

        // TX burst into a 4-deep FIFO: 0x06 is dropped
        for (int k = 0; k < 6; k++) begin
            uart_tx_data = 8'(k + 1);
            uart_tx_req  = 1'b1;
            tick();
            if (k == 4) check("burst no overflow yet", {31'd0, tx_overflow}, 32'd0);
        end
        uart_tx_req = 1'b0;
        check("burst overflow set", {31'd0, tx_overflow}, 32'd1);
        tx_check("burst 01", 10'h202, 4);
        tx_check("burst 02", 10'h204, 0);
        tx_check("burst 03", 10'h206, 0);
        tx_check("burst 04", 10'h208, 0);
        tx_check("burst 05", 10'h20A, 0);
        idle_check("burst 06 not sent", 30);
        check("burst overflow sticky", {31'd0, tx_overflow}, 32'd1);

        // RX frames from table
        foreach (rx_tab[k]) begin
            base_req = rx_req_cnt;
            base_err = rx_err_cnt;
            rx_drive(rx_tab[k].data, rx_tab[k].stop, 0);
            repeat (12) tick();
            check($sformatf("rx%0d req count", k), rx_req_cnt - base_req, rx_tab[k].exp_req);
            check($sformatf("rx%0d err count", k), rx_err_cnt - base_err, rx_tab[k].exp_err);
            check($sformatf("rx%0d data", k), {24'd0, uart_rx_data}, {24'd0, rx_tab[k].exp_data});
        end

        // Framing error with the line held low, then 0x55 after it returns high
        base_req = rx_req_cnt;
        base_err = rx_err_cnt;
        rx_drive(8'h33, 1'b0, 24);
        check("ferr err pulse", rx_err_cnt - base_err, 1);
        check("ferr no req", rx_req_cnt - base_req, 0);
        repeat (4) tick();
        rx_drive(8'h55, 1'b1, 0);
        repeat (12) tick();
        check("ferr then 55 req", rx_req_cnt - base_req, 1);
        check("ferr then 55 data", {24'd0, uart_rx_data}, 32'h55);
        check("ferr then 55 no err", rx_err_cnt - base_err, 1);

        // Two-cycle glitch: nothing happens
        base_req = rx_req_cnt;
        base_err = rx_err_cnt;
        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        repeat (100) tick();
        check("glitch no req", rx_req_cnt - base_req, 0);
        check("glitch no err", rx_err_cnt - base_err, 0);
        check("glitch data kept", {24'd0, uart_rx_data}, 32'h55);

        // RTS follows the RX FIFO almost-full flag one cycle later
        uart_rx_fifo_full = 1'b0;
        repeat (2) tick();
        check("rts low", {31'd0, rts_n}, 32'd0);
        uart_rx_fifo_full = 1'b1;
        #2;
        check("rts not yet", {31'd0, rts_n}, 32'd0);
        tick();
        check("rts high", {31'd0, rts_n}, 32'd1);
        uart_rx_fifo_full = 1'b0;
        tick();

`ifdef UART_CTS_EN
        // CTS gating: a queued byte waits for cts_n low
        cts_n = 1'b1;
        repeat (4) tick();
        tx_write(8'h10);
        idle_check_busy: begin
            logic bad = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (txd !== 1'b1) bad = 1'b1;
                tick();
            end
            check("cts hold txd", {31'd0, bad}, 32'd0);
        end
        check("cts hold busy", {31'd0, tx_busy}, 32'd1);
        cts_n = 1'b0;
        n = 0;
        while (n < 6 && txd !== 1'b0) begin
            tick();
            n = n + 1;
        end
        check("cts fall within 4", {31'd0, (n >= 1 && n <= 4)}, 32'd1);
        if (txd === 1'b0) tx_check("cts 10", 10'h220, 0);
        repeat (4) tick();
`endif

        // Reset in the middle of data bit 4 of 0x25 with 0x77 queued
        uart_tx_data = 8'h25;
        uart_tx_req  = 1'b1;
        tick();
        uart_tx_data = 8'h77;
        tick();
        uart_tx_req = 1'b0;
        check("mid start bit", {31'd0, txd}, 32'd0);
        repeat (5 * DIV + 3) tick();
        check("mid bit4 low", {31'd0, txd}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid reset txd", {31'd0, txd}, 32'd1);
        check("mid reset busy", {31'd0, tx_busy}, 32'd0);
        check("mid reset overflow", {31'd0, tx_overflow}, 32'd0);
        @(posedge clk_bus);
        #1;
        reset = 1'b0;
        idle_check("post reset fifo empty", 20);
        tx_write(8'h81);
        tick();
        tx_check("post reset 81", 10'h302, 0);
        check("post reset 81 busy", {31'd0, tx_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
